i2c_shift_reg_slave: RTL
========================

// Module: i2c_shift_reg_slave
// PURPOSE
//  Parametrised full-duplex shift register for the I2C slave datapath.
//  Loads a WIDTH-bit word in parallel and drives it serially on Out.
//  Captures SerIn into a parallel receive word on the same bit strobes.
//  Sits between the slave byte FSM (Load/Done) and the SCL-edge detector (ShiftEn).
// PARAMETERS
//  WIDTH      8  word length in bits; legal values are WIDTH >= 2
//  MSB_FIRST  1  1 = transmit/receive bit WIDTH-1 first; 0 = bit 0 first
//  IDLE_OUT   1  Out level when no word is active (1 = SDA released)
// PORTS
//  Clk     in   1      single clock; all state changes on posedge Clk
//  Rst     in   1      synchronous reset, active-high
//  In      in   WIDTH  parallel transmit word, sampled when Load & Ready
//  Load    in   1      request to start a word
//  Ready   out  1      combinational, equal to !Busy; Load is accepted only when high
//  ShiftEn in   1      one-cycle bit strobe from the SCL-edge detector
//  SerIn   in   1      serial receive bit, sampled on ShiftEn cycles while Busy
//  Abort   in   1      synchronous abort (STOP/repeated START seen)
//  Out     out  1      serial transmit bit, registered
//  Busy    out  1      a word is in progress
//  Done    out  1      one-cycle pulse after the last bit completes
//  RxData  out  WIDTH  last fully received word, registered
// BEHAVIOUR
//  Reset (Rst=1 at posedge): Out=IDLE_OUT, Busy=0, Done=0, RxData=0,
//   tx/rx shift regs=0, Cnt=0, state=IDLE. Rst overrides every other input.
//  Priority, per cycle: Rst > Abort > Load > ShiftEn.
//  Cnt width is $clog2(WIDTH+1). It counts completed bits from 0 to WIDTH.
//  IDLE (Busy=0, Ready=1):
//   - Load=1: txreg<=In, Cnt<=0, Busy<=1, go SHIFT.
//   - On that same edge, Out<=first bit: In[WIDTH-1] if MSB_FIRST, else In[0].
//     The first bit is therefore valid before the first ShiftEn.
//   - ShiftEn in IDLE is ignored. If Load and ShiftEn coincide, load only.
//  SHIFT (Busy=1, Ready=0):
//   - Load is ignored; In is not sampled.
//   - ShiftEn=1 and Cnt<WIDTH-1: rxreg shifts SerIn in, txreg advances one bit,
//     Out<=next tx bit, Cnt<=Cnt+1. Out changes on the edge after the strobe.
//   - MSB_FIRST=1: rx shifts left, SerIn enters bit 0. The first received bit
//     ends in RxData[WIDTH-1].
//   - MSB_FIRST=0: rx shifts right, SerIn enters bit WIDTH-1. The first received
//     bit ends in RxData[0].
//   - ShiftEn=1 and Cnt==WIDTH-1 (last bit):
//     * RxData<={rxreg, SerIn}, with ordering as above.
//     * Out<=IDLE_OUT, Busy<=0, Done<=1, Cnt<=0, go IDLE.
//   - ShiftEn=0: hold all state. Any gap between strobes is legal.
//  Done is high exactly one cycle. Ready is already 1 in the Done cycle, so a
//   Load in the Done cycle is accepted; back-to-back words need no idle cycle.
//  Abort=1 in any state: go IDLE, Out<=IDLE_OUT, Busy<=0, Cnt<=0, no Done.
//   RxData keeps its previous value. Abort in IDLE is a no-op.
//  RxData changes only on a last-bit strobe or on Rst.
// TESTING
//  T1 WIDTH=8, MSB_FIRST=1: load 0xA5, 8 ShiftEn strobes spaced 3 cycles,
//     SerIn bits 0,0,1,1,1,1,0,0 -> Out 1,0,1,0,0,1,0,1 then 1;
//     Done pulses once; RxData=0x3C.
//  T2 MSB_FIRST=0: load 0x01, SerIn bits 1,0,0,0,0,0,0,0 -> Out 1 then seven 0s
//     then 1; RxData=0x01.
//  T3 Load 0x5A while Busy after 3 bits -> ignored; word 0xA5 completes
//     unchanged; Ready=0 throughout.
//  T4 Abort after 4 bits -> next cycle Busy=0, Out=1, no Done, RxData unchanged;
//     a new load of 0xFF then runs all 8 bits.
//  T5 Load 0xC3 in the Done cycle of a previous word -> accepted;
//     Out=1 (bit7 of 0xC3) on the next cycle.
//  T6 Rst mid-word with ShiftEn=1 and Load=1 -> all outputs at reset values,
//     Ready=1; compare against a WIDTH=12 build with random ShiftEn gaps.

Source files
------------

// File: rtl/i2c_shift_reg_slave.sv
// Full-duplex parallel/serial shift register for the I2C slave datapath.
// Transmits a loaded word on Out and assembles the received word on RxData.
module i2c_shift_reg_slave #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_OUT  = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] In,
  input  logic             Load,
  output logic             Ready,
  input  logic             ShiftEn,
  input  logic             SerIn,
  input  logic             Abort,
  output logic             Out,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] RxData
);

  localparam int unsigned    CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] rxdata_q, rxdata_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             done_q, done_d;

  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] tx_shifted;
  logic [WIDTH-1:0] rx_shifted;

  // Bit-order dependent views of the shift registers.
  always_comb begin
    if (MSB_FIRST) begin
      first_bit  = In[WIDTH-1];
      next_bit   = tx_q[WIDTH-2];
      tx_shifted = {tx_q[WIDTH-2:0], 1'b0};
      rx_shifted = {rx_q[WIDTH-2:0], SerIn};
    end else begin
      first_bit  = In[0];
      next_bit   = tx_q[1];
      tx_shifted = {1'b0, tx_q[WIDTH-1:1]};
      rx_shifted = {SerIn, rx_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= StIdle;
      tx_q     <= '0;
      rx_q     <= '0;
      rxdata_q <= '0;
      cnt_q    <= '0;
      out_q    <= IDLE_OUT;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rxdata_q <= rxdata_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rxdata_d = rxdata_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    done_d   = 1'b0;

    if (Abort) begin
      // Drops the word without a Done pulse; RxData keeps the last full word.
      state_d = StIdle;
      out_d   = IDLE_OUT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Load) begin
            tx_d    = In;
            cnt_d   = '0;
            out_d   = first_bit;
            state_d = StShift;
          end
        end
        StShift: begin
          if (ShiftEn) begin
            rx_d = rx_shifted;
            if (cnt_q == LastCnt) begin
              rxdata_d = rx_shifted;
              out_d    = IDLE_OUT;
              done_d   = 1'b1;
              cnt_d    = '0;
              state_d  = StIdle;
            end else begin
              tx_d  = tx_shifted;
              out_d = next_bit;
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    Busy   = (state_q == StShift);
    Ready  = (state_q != StShift);
    Out    = out_q;
    Done   = done_q;
    RxData = rxdata_q;
  end

endmodule
